// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned MEM_LATENCY      = 2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic        valid;
    logic        epoch;
    logic [31:0] pc;
  } inflight_t;

endpackage

// File: rtl/program_memory_bus.sv
// Program memory read port: word address out, instruction back a fixed latency later.
interface program_memory_bus;

  logic [31:0] addr;
  logic        read_request;
  logic [31:0] instr;
  logic        data_valid;

  modport CONSUMER (output addr, read_request, input instr, data_valid);
  modport PROVIDER (input addr, read_request, output instr, data_valid);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through buffer for fetched instructions.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           flush,
  input  logic                           push,
  input  entry_t                         push_data,
  input  logic                           pop,
  output entry_t                         head,
  output logic [$clog2(DEPTH + 1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited issue, in-flight epoch tracking, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  program_memory_bus.CONSUMER       bus,
  input  logic                      redirect_in,
  input  logic [31:0]               redirect_pc_in,
  output logic [31:0]               instr_out,
  output logic [31:0]               pc_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      err_out
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]            pc;
  logic                   epoch;
  logic [MEM_LATENCY-1:0] guard;
  inflight_t              stage [MEM_LATENCY];
  inflight_t              resp;
  logic [5:0]             in_flight;
  logic [5:0]             occupancy;
  logic [CW-1:0]          fifo_count;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   spurious;
  fetch_entry_t           push_entry;
  fetch_entry_t           head_entry;
  logic                   unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_in[1:0];

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
      in_flight = in_flight + 6'(stage[i].valid);
    end
  end

  assign occupancy = in_flight + 6'(fifo_count);
  assign issue     = rst_n_in && !redirect_in && (occupancy < 6'(FIFO_DEPTH));
  assign resp      = stage[MEM_LATENCY-1];

  assign bus.read_request = issue;
  assign bus.addr         = {2'b00, pc[31:2]};

  // guard[0] masks responses to requests abandoned by a reset.
  assign push     = bus.data_valid && !guard[0] && resp.valid && (resp.epoch == epoch) && !redirect_in;
  assign spurious = bus.data_valid && !guard[0] && !resp.valid;
  assign pop      = valid_out && ready_in;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = resp.pc;
    push_entry.instr = bus.instr;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc      <= {RESET_PC[31:2], 2'b00};
      epoch   <= 1'b0;
      guard   <= '1;
      err_out <= 1'b0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      guard <= guard >> 1;
      if (spurious) err_out <= 1'b1;
      stage[0] <= '{valid: issue, epoch: epoch, pc: pc};
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
      if (redirect_in) begin
        pc    <= {redirect_pc_in[31:2], 2'b00};
        epoch <= ~epoch;
      end else if (issue) begin
        pc <= pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .flush     (redirect_in),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count)
  );

  assign valid_out = (fifo_count != '0);
  assign instr_out = head_entry.instr;
  assign pc_out    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-based reference of the fetch stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        ready_in;
  logic        err_out;

  program_memory_bus bus ();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .bus            (bus),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .err_out        (err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    int          gen;
    int          cyc;
  } req_t;

  fetch_entry_t q_fifo [$];
  req_t         q_infl [$];
  logic [31:0]  m_pc;
  int           m_gen;
  logic         m_err;
  int           cyc;
  int           rst_cyc;
  int           first_req;
  int           first_val;
  logic         h_v [2];
  logic [31:0]  h_a [2];
  bit           redir_on_pc8;
  bit           pc8_hit;
  bit           expect_100;
  int           n_checks;
  int           n_bad;

  function automatic logic [31:0] mem_word(input logic [31:0] word_addr);
    return (word_addr * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                      input bit inj, input bit do_rst);
    bit          exp_valid;
    bit          exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    @(posedge clk_in);
    #1;
    if (redir_on_pc8 && valid_out && pc_out == 32'h8) begin
      redir        = 1'b1;
      rpc          = 32'h100;
      redir_on_pc8 = 1'b0;
      pc8_hit      = 1'b1;
    end
    redirect_in    = redir;
    redirect_pc_in = rpc;
    ready_in       = rdy;
    if (h_v[1]) begin
      bus.data_valid = 1'b1;
      bus.instr      = mem_word(h_a[1]);
    end else begin
      bus.data_valid = inj;
      bus.instr      = $urandom;
    end
    if (do_rst) begin
      #1 rst_n_in = 1'b0;
      #1;
      check_eq("rst_valid", valid_out, 0);
      check_eq("rst_pc_out", pc_out, 0);
      check_eq("rst_instr", instr_out, 0);
      check_eq("rst_err", err_out, 0);
      check_eq("rst_req", bus.read_request, 0);
      m_pc = 32'h0;
      m_err = 1'b0;
      q_fifo.delete();
      q_infl.delete();
      rst_cyc = cyc;
      first_req = -1;
      first_val = -1;
      #1 rst_n_in = 1'b1;
    end
    @(negedge clk_in);
    exp_valid = (q_fifo.size() != 0);
    exp_pc    = exp_valid ? q_fifo[0].pc : 32'h0;
    exp_instr = exp_valid ? q_fifo[0].instr : 32'h0;
    exp_req   = !redir && ((q_infl.size() + q_fifo.size()) < DEPTH);
    check_eq("valid_out", valid_out, exp_valid);
    check_eq("pc_out", pc_out, exp_pc);
    check_eq("instr_out", instr_out, exp_instr);
    check_eq("read_request", bus.read_request, exp_req);
    check_eq("addr", bus.addr, {2'b00, m_pc[31:2]});
    check_eq("err_out", err_out, m_err);
    if (first_req < 0 && bus.read_request) first_req = cyc;
    if (first_val < 0 && first_req >= 0 && valid_out) begin
      first_val = cyc;
      check_eq("fill_latency", cyc - first_req, 3);
    end
    if (expect_100 && valid_out) begin
      check_eq("post_redirect_pc", pc_out, 32'h100);
      expect_100 = 1'b0;
    end
    if (bus.data_valid) begin
      if (q_infl.size() > 0 && q_infl[0].cyc == cyc - 2) begin
        if (q_infl[0].gen == m_gen && !redir)
          q_fifo.push_back('{pc: q_infl[0].pc, instr: mem_word(q_infl[0].pc >> 2)});
      end else if (cyc - rst_cyc >= 2) begin
        m_err = 1'b1;
      end
    end
    while (q_infl.size() > 0 && q_infl[0].cyc <= cyc - 2) void'(q_infl.pop_front());
    if (exp_valid && rdy) void'(q_fifo.pop_front());
    if (redir) begin
      q_fifo.delete();
      m_gen++;
      m_pc = {rpc[31:2], 2'b00};
      if (rpc == 32'h100 && pc8_hit) expect_100 = 1'b1;
    end
    if (exp_req) begin
      q_infl.push_back('{m_pc, m_gen, cyc});
      m_pc = m_pc + 32'd4;
    end
    h_v[1] = h_v[0];
    h_a[1] = h_a[0];
    h_v[0] = bus.read_request;
    h_a[0] = bus.addr;
    cyc++;
  endtask

  initial begin
    logic [31:0] rpc;
    n_checks = 0;
    n_bad = 0;
    cyc = 0;
    rst_cyc = 0;
    m_gen = 0;
    m_pc = 32'h0;
    m_err = 1'b0;
    first_req = -1;
    first_val = -1;
    redir_on_pc8 = 1'b0;
    pc8_hit = 1'b0;
    expect_100 = 1'b0;
    h_v[0] = 1'b0; h_v[1] = 1'b0;
    h_a[0] = '0;   h_a[1] = '0;
    rst_n_in = 1'b0;
    redirect_in = 1'b0;
    redirect_pc_in = '0;
    ready_in = 1'b0;
    bus.data_valid = 1'b0;
    bus.instr = '0;

    repeat (2) @(posedge clk_in);
    #2;
    check_eq("por_valid", valid_out, 0);
    check_eq("por_req", bus.read_request, 0);
    check_eq("por_addr", bus.addr, 0);
    check_eq("por_err", err_out, 0);

    // straight-line stream from reset
    step(0, '0, 1, 0, 1);
    repeat (30) step(0, '0, 1, 0, 0);

    // backpressure from a fresh reset, then release
    step(0, '0, 0, 0, 1);
    repeat (20) step(0, '0, 0, 0, 0);
    repeat (10) step(0, '0, 1, 0, 0);

    // redirect to 0x100 when pc 8 is at the head
    step(0, '0, 1, 0, 1);
    redir_on_pc8 = 1'b1;
    pc8_hit = 1'b0;
    repeat (20) step(0, '0, 1, 0, 0);
    check_eq("redirect_at_pc8", pc8_hit, 1);

    // unaligned redirect near the top of the address space
    step(1, 32'hFFFF_FFFB, 1, 0, 0);
    repeat (12) step(0, '0, 1, 0, 0);

    // back-to-back redirects
    step(1, 32'h0000_2000, 1, 0, 0);
    step(1, 32'h0000_3004, 1, 0, 0);
    repeat (8) step(0, '0, 1, 0, 0);

    repeat (400) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step($urandom_range(0, 9) == 0, rpc, $urandom_range(0, 3) != 0, 0, 0);
    end

    // spurious response with nothing in flight
    repeat (8) step(0, '0, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    repeat (4) step(0, '0, 0, 0, 0);
    check_eq("err_sticky", err_out, 1);
    repeat (6) step(0, '0, 1, 0, 0);

    // async reset mid-stream
    repeat (5) step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 1);
    repeat (20) step(0, '0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
